// File: rtl/dm_pkg.sv
// Shared debug-module types.
// Holds the CSR address map, the DMI op and response codes, and the request and
// response structs used between the DTM link and the CSR sequencer.
package dm_pkg;

  // Number of abstract data registers implemented.
  localparam logic [3:0] DataCount = 4'd2;

  typedef enum logic [6:0] {
    Data0      = 7'h04,
    Data1      = 7'h05,
    DMControl  = 7'h10,
    DMStatus   = 7'h11,
    Hartinfo   = 7'h12,
    AbstractCS = 7'h16,
    Command    = 7'h17
  } dm_csr_t;

  typedef enum logic [1:0] {
    DtmNop   = 2'd0,
    DtmRead  = 2'd1,
    DtmWrite = 2'd2
  } dtm_op_e;

  typedef enum logic [1:0] {
    DmiSuccess = 2'd0,
    DmiFailed  = 2'd2,
    DmiBusy    = 2'd3
  } dmi_resp_e;

  // The op field stays a raw 2-bit code: value 3 is legal on the wire and must be
  // answered with a failure rather than being folded into a named op.
  typedef struct packed {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

endpackage

// File: rtl/dm_resp_fifo.sv
// Synchronous FIFO of DMI responses.
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/data_i write side;
// pop_i read side; full_o/empty_o status; head_o the oldest entry.
module dm_resp_fifo
  import dm_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      push_i,
  input  dmi_resp_t data_i,
  input  logic      pop_i,
  output logic      full_o,
  output logic      empty_o,
  output dmi_resp_t head_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  dmi_resp_t            mem_q [Depth];
  logic      [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic      [CntW-1:0] cnt_q, cnt_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(Depth - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_i) rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

endmodule

// File: rtl/dmi_csr_sequencer.sv
// DMI-to-CSR sequencer.
// Accepts NOP/READ/WRITE requests from the DTM, issues each as a one-cycle strobe
// to the CSR decoder, and queues the response so DTM back-pressure never stalls
// the CSR block.
// Ports: clk_i/rst_ni; dmi_req_* request link; csr_* decoder strobe interface;
// dmi_resp_* buffered response link.
module dmi_csr_sequencer
  import dm_pkg::*;
#(
  parameter int unsigned RespDepth = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        dmi_req_valid_i,
  output logic        dmi_req_ready_o,
  input  logic [6:0]  dmi_req_addr_i,
  input  logic [1:0]  dmi_req_op_i,
  input  logic [31:0] dmi_req_data_i,
  output logic [6:0]  csr_addr_o,
  output logic        csr_re_o,
  output logic        csr_we_o,
  output logic [31:0] csr_wdata_o,
  input  logic [31:0] csr_rdata_i,
  output logic        dmi_resp_valid_o,
  input  logic        dmi_resp_ready_i,
  output logic [31:0] dmi_resp_data_o,
  output logic [1:0]  dmi_resp_o
);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StAccess = 1'b1;

  logic [0:0] state_q, state_d;
  dmi_req_t   req_q;
  logic       req_fire;
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  dmi_resp_t  push_data, head;

  // Ready is gated by full in IDLE, so the ACCESS push always finds a free slot.
  assign dmi_req_ready_o = (state_q == StIdle) && !fifo_full;
  assign req_fire        = dmi_req_valid_i && dmi_req_ready_o;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (req_fire) state_d = StAccess;
      StAccess: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      if (req_fire) begin
        req_q.addr <= dmi_req_addr_i;
        req_q.op   <= dmi_req_op_i;
        req_q.data <= dmi_req_data_i;
      end
    end
  end

  // req_q only changes when entering ACCESS, so address and data hold elsewhere.
  assign csr_addr_o  = req_q.addr;
  assign csr_wdata_o = req_q.data;
  assign csr_re_o    = (state_q == StAccess) && (req_q.op == DtmRead);
  assign csr_we_o    = (state_q == StAccess) && (req_q.op == DtmWrite);

  always_comb begin
    push_data.data = '0;
    push_data.resp = DmiSuccess;
    if (req_q.op == DtmRead) push_data.data = csr_rdata_i;
    if (req_q.op == 2'd3)    push_data.resp = DmiFailed;
  end

  assign fifo_push = (state_q == StAccess);
  assign fifo_pop  = dmi_resp_valid_o && dmi_resp_ready_i;

  dm_resp_fifo #(
    .Depth(RespDepth)
  ) u_resp_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (fifo_push),
    .data_i (push_data),
    .pop_i  (fifo_pop),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .head_o (head)
  );

  // Mask the stale head so the response bus reads zero when nothing is queued.
  assign dmi_resp_valid_o = !fifo_empty;
  assign dmi_resp_data_o  = fifo_empty ? 32'h0 : head.data;
  assign dmi_resp_o       = fifo_empty ? 2'd0 : head.resp;

endmodule

// File: tb/tb_dmi_csr_sequencer.sv
// Directed bench for dmi_csr_sequencer: drives and samples 1 time unit after
// each rising edge, checking against hand-computed values.
module tb_dmi_csr_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        dmi_req_valid_i = 1'b0;
  logic        dmi_req_ready_o;
  logic [6:0]  dmi_req_addr_i = '0;
  logic [1:0]  dmi_req_op_i = '0;
  logic [31:0] dmi_req_data_i = '0;
  logic [6:0]  csr_addr_o;
  logic        csr_re_o;
  logic        csr_we_o;
  logic [31:0] csr_wdata_o;
  logic [31:0] csr_rdata_i = '0;
  logic        dmi_resp_valid_o;
  logic        dmi_resp_ready_i = 1'b0;
  logic [31:0] dmi_resp_data_o;
  logic [1:0]  dmi_resp_o;

  int total = 0;
  int bad = 0;

  always #5 clk_i = ~clk_i;

  dmi_csr_sequencer #(
    .RespDepth(2)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .dmi_req_valid_i (dmi_req_valid_i),
    .dmi_req_ready_o (dmi_req_ready_o),
    .dmi_req_addr_i  (dmi_req_addr_i),
    .dmi_req_op_i    (dmi_req_op_i),
    .dmi_req_data_i  (dmi_req_data_i),
    .csr_addr_o      (csr_addr_o),
    .csr_re_o        (csr_re_o),
    .csr_we_o        (csr_we_o),
    .csr_wdata_o     (csr_wdata_o),
    .csr_rdata_i     (csr_rdata_i),
    .dmi_resp_valid_o(dmi_resp_valid_o),
    .dmi_resp_ready_i(dmi_resp_ready_i),
    .dmi_resp_data_o (dmi_resp_data_o),
    .dmi_resp_o      (dmi_resp_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [6:0] addr, input logic [1:0] op, input logic [31:0] data);
    dmi_req_valid_i = 1'b1;
    dmi_req_addr_i  = addr;
    dmi_req_op_i    = op;
    dmi_req_data_i  = data;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_ready", 32'(dmi_req_ready_o), 32'd1);
    check("rst_re", 32'(csr_re_o), 32'd0);
    check("rst_we", 32'(csr_we_o), 32'd0);
    check("rst_addr", 32'(csr_addr_o), 32'd0);
    check("rst_wdata", csr_wdata_o, 32'd0);
    check("rst_rvalid", 32'(dmi_resp_valid_o), 32'd0);
    check("rst_rdata", dmi_resp_data_o, 32'd0);
    check("rst_resp", 32'(dmi_resp_o), 32'd0);
    rst_ni = 1'b1;
    step();
    check("idle_no_re", 32'(csr_re_o), 32'd0);

    // 1: READ 0x04
    dmi_resp_ready_i = 1'b1;
    drive(7'h04, 2'd1, 32'h0);
    csr_rdata_i = 32'h0000007B;
    check("t1_ready", 32'(dmi_req_ready_o), 32'd1);
    step();
    dmi_req_valid_i = 1'b0;
    check("t1_re", 32'(csr_re_o), 32'd1);
    check("t1_we", 32'(csr_we_o), 32'd0);
    check("t1_addr", 32'(csr_addr_o), 32'h04);
    check("t1_ready_access", 32'(dmi_req_ready_o), 32'd0);
    check("t1_no_early_resp", 32'(dmi_resp_valid_o), 32'd0);
    step();
    check("t1_re_off", 32'(csr_re_o), 32'd0);
    check("t1_rvalid", 32'(dmi_resp_valid_o), 32'd1);
    check("t1_rdata", dmi_resp_data_o, 32'h7B);
    check("t1_resp", 32'(dmi_resp_o), 32'd0);
    step();
    check("t1_popped", 32'(dmi_resp_valid_o), 32'd0);

    // 2: WRITE 0x17
    drive(7'h17, 2'd2, 32'hDEADBEEF);
    csr_rdata_i = 32'h12345678;
    step();
    dmi_req_valid_i = 1'b0;
    check("t2_we", 32'(csr_we_o), 32'd1);
    check("t2_re", 32'(csr_re_o), 32'd0);
    check("t2_wdata", csr_wdata_o, 32'hDEADBEEF);
    check("t2_addr", 32'(csr_addr_o), 32'h17);
    step();
    check("t2_we_off", 32'(csr_we_o), 32'd0);
    check("t2_rvalid", 32'(dmi_resp_valid_o), 32'd1);
    check("t2_rdata", dmi_resp_data_o, 32'h0);
    check("t2_resp", 32'(dmi_resp_o), 32'd0);
    check("t2_addr_hold", 32'(csr_addr_o), 32'h17);
    check("t2_wdata_hold", csr_wdata_o, 32'hDEADBEEF);
    step();

    // 3: reserved op
    drive(7'h10, 2'd3, 32'h0);
    step();
    dmi_req_valid_i = 1'b0;
    check("t3_re", 32'(csr_re_o), 32'd0);
    check("t3_we", 32'(csr_we_o), 32'd0);
    step();
    check("t3_rvalid", 32'(dmi_resp_valid_o), 32'd1);
    check("t3_rdata", dmi_resp_data_o, 32'h0);
    check("t3_resp", 32'(dmi_resp_o), 32'd2);
    step();

    // 4: back-pressure with three READs
    dmi_resp_ready_i = 1'b0;
    drive(7'h05, 2'd1, 32'h0);
    csr_rdata_i = 32'hA1;
    step();
    check("t4_re1", 32'(csr_re_o), 32'd1);
    step();
    check("t4_ready_1q", 32'(dmi_req_ready_o), 32'd1);
    check("t4_head1", dmi_resp_data_o, 32'hA1);
    dmi_req_addr_i = 7'h06;
    csr_rdata_i = 32'hA2;
    step();
    check("t4_re2", 32'(csr_re_o), 32'd1);
    step();
    check("t4_full_ready", 32'(dmi_req_ready_o), 32'd0);
    dmi_req_addr_i = 7'h07;
    csr_rdata_i = 32'hA3;
    step();
    check("t4_full_ready2", 32'(dmi_req_ready_o), 32'd0);
    check("t4_no_strobe", 32'(csr_re_o), 32'd0);
    check("t4_head_hold", dmi_resp_data_o, 32'hA1);
    dmi_resp_ready_i = 1'b1;
    step();
    check("t4_head2", dmi_resp_data_o, 32'hA2);
    check("t4_ready_back", 32'(dmi_req_ready_o), 32'd1);
    step();
    dmi_req_valid_i = 1'b0;
    check("t4_re3", 32'(csr_re_o), 32'd1);
    check("t4_addr3", 32'(csr_addr_o), 32'h07);
    check("t4_empty", 32'(dmi_resp_valid_o), 32'd0);
    step();
    check("t4_head3", dmi_resp_data_o, 32'hA3);
    step();
    check("t4_drained", 32'(dmi_resp_valid_o), 32'd0);

    // 5: simultaneous push and pop, then sustained traffic across pointer wrap
    dmi_resp_ready_i = 1'b0;
    drive(7'h04, 2'd1, 32'h0);
    csr_rdata_i = 32'hB1;
    step();
    step();
    drive(7'h05, 2'd1, 32'h0);
    csr_rdata_i = 32'hB2;
    step();
    dmi_req_valid_i = 1'b0;
    check("t5_head_b1", dmi_resp_data_o, 32'hB1);
    dmi_resp_ready_i = 1'b1;
    step();
    check("t5_valid_after_pp", 32'(dmi_resp_valid_o), 32'd1);
    check("t5_head_b2", dmi_resp_data_o, 32'hB2);
    check("t5_ready_cnt1", 32'(dmi_req_ready_o), 32'd1);
    for (int i = 0; i < 5; i++) begin
      drive(7'(7'h04 + i), 2'd1, 32'h0);
      csr_rdata_i = 32'hC0 + 32'(i);
      step();
      dmi_req_valid_i = 1'b0;
      check("t5_loop_re", 32'(csr_re_o), 32'd1);
      step();
      check("t5_loop_data", dmi_resp_data_o, 32'hC0 + 32'(i));
    end
    step();
    check("t5_drained", 32'(dmi_resp_valid_o), 32'd0);

    // 6: reset during ACCESS with a response queued
    dmi_resp_ready_i = 1'b0;
    drive(7'h04, 2'd1, 32'h0);
    csr_rdata_i = 32'hD1;
    step();
    step();
    drive(7'h05, 2'd1, 32'h0);
    step();
    dmi_req_valid_i = 1'b0;
    check("t6_re_pre", 32'(csr_re_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("t6_re_async", 32'(csr_re_o), 32'd0);
    check("t6_rvalid_async", 32'(dmi_resp_valid_o), 32'd0);
    check("t6_ready_async", 32'(dmi_req_ready_o), 32'd1);
    step();
    rst_ni = 1'b1;
    step();
    check("t6_ready_after", 32'(dmi_req_ready_o), 32'd1);
    check("t6_re_after", 32'(csr_re_o), 32'd0);
    check("t6_rvalid_after", 32'(dmi_resp_valid_o), 32'd0);
    check("t6_rdata_after", dmi_resp_data_o, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
